conv_processor_mac_seq: RTL and testbench

//  Sequencer and multiply-accumulate datapath for the 1-D convolution core.

---
 rtl/conv_processor_pkg.sv | 27 ++
 rtl/conv_processor_mac_dp.sv | 38 +++
 rtl/conv_processor_mac_seq.sv | 153 +++++++++++++++
 tb/tb_conv_processor_mac_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_processor_pkg.sv
// Shared definitions for the convolution core: FSM state encoding, width helper, data typedefs.
// The CONV_PROC_SIGNED_EN macro selects signed sample arithmetic.
package conv_processor_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    // The accumulator holds up to 2**ADDR_WIDTH full-scale products without wrapping.
    function automatic int accWidth(input int dataWidth, input int addrWidth);
        return 2 * dataWidth + addrWidth;
    endfunction

    localparam int DEF_ACC_WIDTH = accWidth(DEF_DATA_WIDTH, DEF_ADDR_WIDTH);

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
    typedef logic [DEF_ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        IDX  = 3'd2,
        MAC  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/conv_processor_mac_dp.sv
// Multiply-accumulate datapath: extends X*Y to accumulator width and adds the running sum.
// With CONV_PROC_SIGNED_EN defined the operands are two's complement and the product is sign-extended.
module conv_processor_mac_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [ACC_WIDTH-1:0]  sum_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        product;
    logic [ACC_WIDTH-1:0] productExt;

`ifdef CONV_PROC_SIGNED_EN
    logic signed [PW-1:0] xExt;
    logic signed [PW-1:0] yExt;

    assign xExt       = $signed({{DATA_WIDTH{x_i[DATA_WIDTH-1]}}, x_i});
    assign yExt       = $signed({{DATA_WIDTH{y_i[DATA_WIDTH-1]}}, y_i});
    assign product    = xExt * yExt;
    assign productExt = {{(ACC_WIDTH-PW){product[PW-1]}}, product};
`else
    logic [PW-1:0] xExt;
    logic [PW-1:0] yExt;

    assign xExt       = {{DATA_WIDTH{1'b0}}, x_i};
    assign yExt       = {{DATA_WIDTH{1'b0}}, y_i};
    assign product    = xExt * yExt;
    assign productExt = {{(ACC_WIDTH-PW){1'b0}}, product};
`endif

    assign sum_o = acc_i + productExt;

endmodule

// File: rtl/conv_processor_mac_seq.sv
// Convolution sequencer: walks output index i and tap index j, drives X/Y reads and accumulator strobes,
// and writes each finished sum to Z. CONV_PROC_SIGNED_EN (in the datapath) selects signed samples.
module conv_processor_mac_seq
    import conv_processor_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH  = accWidth(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   size_x,
    input  logic [ADDR_WIDTH:0]   size_y,
    output logic [ADDR_WIDTH-1:0] memx_addr,
    input  logic [DATA_WIDTH-1:0] memx_data,
    output logic [ADDR_WIDTH-1:0] memy_addr,
    input  logic [DATA_WIDTH-1:0] memy_data,
    output logic                  acc_clear,
    output logic                  acc_load,
    output logic [ACC_WIDTH-1:0]  acc_next,
    input  logic [ACC_WIDTH-1:0]  acc_q,
    output logic [ADDR_WIDTH:0]   memz_addr,
    output logic [ACC_WIDTH-1:0]  memz_data,
    output logic                  memz_we,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = ADDR_WIDTH + 1;
    localparam logic [SW-1:0] MAX_SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [SW-1:0]         iCnt_q, iCnt_d;
    logic [ADDR_WIDTH-1:0] jCnt_q, jCnt_d;
    logic [SW-1:0]         sizeX_q, sizeX_d;
    logic [SW-1:0]         sizeY_q, sizeY_d;
    logic [ADDR_WIDTH-1:0] memxAddr_q, memxAddr_d;
    logic [ADDR_WIDTH-1:0] memyAddr_q, memyAddr_d;

    logic [SW-1:0]         sizeXSat, sizeYSat;
    logic [SW-1:0]         kDiff;
    logic [SW:0]           sumSizes;
    logic                  termValid, lastJ, lastI;
    logic [ACC_WIDTH-1:0]  dpSum;

    assign sizeXSat = (size_x > MAX_SIZE) ? MAX_SIZE : size_x;
    assign sizeYSat = (size_y > MAX_SIZE) ? MAX_SIZE : size_y;

    // A term exists only when k = i - j lands inside X; otherwise it is skipped without a MAC cycle.
    assign kDiff     = iCnt_q - {1'b0, jCnt_q};
    assign termValid = (iCnt_q >= {1'b0, jCnt_q}) && (kDiff < sizeX_q);
    assign lastJ     = ({1'b0, jCnt_q} == (sizeY_q - SW'(1)));
    assign sumSizes  = {1'b0, sizeX_q} + {1'b0, sizeY_q};
    assign lastI     = ({1'b0, iCnt_q} == (sumSizes - (SW+1)'(2)));

    conv_processor_mac_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_dp (
        .x_i   (memx_data),
        .y_i   (memy_data),
        .acc_i (acc_q),
        .sum_o (dpSum)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            iCnt_q     <= '0;
            jCnt_q     <= '0;
            sizeX_q    <= '0;
            sizeY_q    <= '0;
            memxAddr_q <= '0;
            memyAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            iCnt_q     <= iCnt_d;
            jCnt_q     <= jCnt_d;
            sizeX_q    <= sizeX_d;
            sizeY_q    <= sizeY_d;
            memxAddr_q <= memxAddr_d;
            memyAddr_q <= memyAddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iCnt_d     = iCnt_q;
        jCnt_d     = jCnt_q;
        sizeX_d    = sizeX_q;
        sizeY_d    = sizeY_q;
        memxAddr_d = memxAddr_q;
        memyAddr_d = memyAddr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sizeX_d = sizeXSat;
                    sizeY_d = sizeYSat;
                    iCnt_d  = '0;
                    state_d = ((sizeXSat == '0) || (sizeYSat == '0)) ? DONE : CLR;
                end
            end
            CLR: begin
                jCnt_d  = '0;
                state_d = IDX;
            end
            IDX: begin
                if (termValid) begin
                    memxAddr_d = kDiff[ADDR_WIDTH-1:0];
                    memyAddr_d = jCnt_q;
                    state_d    = MAC;
                end else if (lastJ) begin
                    state_d = WR;
                end else begin
                    jCnt_d = jCnt_q + ADDR_WIDTH'(1);
                end
            end
            MAC: begin
                if (lastJ) begin
                    state_d = WR;
                end else begin
                    jCnt_d  = jCnt_q + ADDR_WIDTH'(1);
                    state_d = IDX;
                end
            end
            WR: begin
                if (lastI) begin
                    state_d = DONE;
                end else begin
                    iCnt_d  = iCnt_q + SW'(1);
                    state_d = CLR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAMs are synchronous, so the IDX address must reach them combinationally to be valid in MAC.
    assign memx_addr = memxAddr_d;
    assign memy_addr = memyAddr_d;

    assign acc_clear = (state_q == CLR);
    assign acc_load  = (state_q == MAC);
    assign acc_next  = (state_q == MAC) ? dpSum : '0;
    assign memz_we   = (state_q == WR);
    assign memz_addr = (state_q == WR) ? iCnt_q : '0;
    assign memz_data = (state_q == WR) ? acc_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_processor_mac_seq.sv
// Testbench for conv_processor_mac_seq: X/Y sync RAMs and accumulator register around the DUT,
// a loop-based convolution reference feeding a Z-write scoreboard. Honours CONV_PROC_SIGNED_EN.
module tb_conv_processor_mac_seq;
    import conv_processor_pkg::*;

    localparam int DW   = DEF_DATA_WIDTH;
    localparam int AW   = DEF_ADDR_WIDTH;
    localparam int AccW = accWidth(DW, AW);
    localparam int SW   = AW + 1;
    localparam int MAXN = 1 << AW;
    localparam int TIMEOUT = 8000;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [SW-1:0]   sizeX, sizeY;
    logic [AW-1:0]   memxAddr, memyAddr;
    logic [DW-1:0]   memxData, memyData;
    logic            accClear, accLoad;
    logic [AccW-1:0] accNext, accQ;
    logic [SW-1:0]   memzAddr;
    logic [AccW-1:0] memzData;
    logic            memzWe, busy, done;

    logic [DW-1:0] xMem [MAXN];
    logic [DW-1:0] yMem [MAXN];

    typedef struct {
        logic [SW-1:0] addr;
        acc_t          data;
    } zWrite_t;

    zWrite_t expQ[$];
    int errors = 0;
    int checks = 0;
    int writesSeen = 0;

    conv_processor_mac_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .size_x    (sizeX),
        .size_y    (sizeY),
        .memx_addr (memxAddr),
        .memx_data (memxData),
        .memy_addr (memyAddr),
        .memy_data (memyData),
        .acc_clear (accClear),
        .acc_load  (accLoad),
        .acc_next  (accNext),
        .acc_q     (accQ),
        .memz_addr (memzAddr),
        .memz_data (memzData),
        .memz_we   (memzWe),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        memxData <= xMem[memxAddr];
        memyData <= yMem[memyAddr];
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn)         accQ <= '0;
        else if (accClear) accQ <= '0;
        else if (accLoad)  accQ <= accNext;
    end

    function automatic void checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic longint sampleVal(input logic [DW-1:0] s);
`ifdef CONV_PROC_SIGNED_EN
        return longint'($signed(s));
`else
        return longint'(s);
`endif
    endfunction

    // Z[i] = sum X[i-j]*Y[j]; cycle cost per output is 2 + 2*valid + skipped, plus one DONE cycle.
    task automatic buildExpected(input int sxIn, input int syIn, output int latency, output int nWrites);
        int sx;
        int sy;
        sx = (sxIn > MAXN) ? MAXN : sxIn;
        sy = (syIn > MAXN) ? MAXN : syIn;
        latency = 1;
        nWrites = 0;
        if (sx == 0 || sy == 0) return;
        for (int i = 0; i < sx + sy - 1; i++) begin
            longint z;
            int valid;
            int skipped;
            zWrite_t e;
            z = 0; valid = 0; skipped = 0;
            for (int j = 0; j < sy; j++) begin
                if (i - j >= 0 && i - j < sx) begin
                    z += sampleVal(xMem[i-j]) * sampleVal(yMem[j]);
                    valid++;
                end else begin
                    skipped++;
                end
            end
            latency += 2 + 2 * valid + skipped;
            e.addr = SW'(i);
            e.data = AccW'(z);
            expQ.push_back(e);
            nWrites++;
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (accClear || accLoad) checkOutput("strobeExclusive", 64'(accClear & accLoad), 64'd0);
            if (memzWe) begin
                writesSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", 64'd1, 64'd0);
                end else begin
                    zWrite_t e;
                    e = expQ.pop_front();
                    checkOutput("zAddr", 64'(memzAddr), 64'(e.addr));
                    checkOutput("zData", 64'(memzData), 64'(e.data));
                end
            end
        end
    end

    task automatic fillRandom();
        for (int k = 0; k < MAXN; k++) begin
            xMem[k] = DW'($urandom);
            yMem[k] = DW'($urandom);
        end
    endtask

    // Runs one convolution; midStartAt > 0 re-pulses start with other sizes at that cycle of the run.
    task automatic applyStimulus(input int sx, input int sy, input int midStartAt);
        int latency, nWrites, cycles, busyCycles;
        bit sawDone;
        buildExpected(sx, sy, latency, nWrites);
        writesSeen = 0;
        busyCycles = 0;
        sawDone = 0;
        @(negedge clk);
        start = 1'b1;
        sizeX = SW'(sx);
        sizeY = SW'(sy);
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!sawDone && cycles < TIMEOUT) begin
            if (busy) busyCycles++;
            if (done) begin
                sawDone = 1;
            end else begin
                start = (cycles == midStartAt);
                if (cycles == midStartAt) begin
                    sizeX = SW'($urandom_range(1, 3));
                    sizeY = SW'($urandom_range(1, 3));
                end
                @(negedge clk);
                cycles++;
            end
        end
        start = 1'b0;
        checkOutput("doneLatency", 64'(cycles), 64'(latency));
        checkOutput("busyCycles", 64'(busyCycles), 64'(latency));
        checkOutput("writeCount", 64'(writesSeen), 64'(nWrites));
        checkOutput("pendingWrites", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(negedge clk);
        checkOutput("donePulseEnd", 64'(done), 64'd0);
        checkOutput("busyAfterDone", 64'(busy), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".outputs"},
            64'({memzWe, busy, done, accClear, accLoad}), 64'd0);
        checkOutput({tag, ".addrs"}, 64'({memxAddr, memyAddr, memzAddr}), 64'd0);
        checkOutput({tag, ".data"}, 64'({accNext, memzData}), 64'd0);
    endtask

    task automatic resetMidRun(input int sx, input int sy, input int runCycles);
        int latency, nWrites;
        bit sawWrite;
        buildExpected(sx, sy, latency, nWrites);
        @(negedge clk);
        start = 1'b1;
        sizeX = SW'(sx);
        sizeY = SW'(sy);
        @(negedge clk);
        start = 1'b0;
        repeat (runCycles) @(negedge clk);
        checkOutput("busyBeforeReset", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        checkAllZero("midReset");
        expQ.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        sawWrite = 0;
        repeat (40) begin
            @(negedge clk);
            if (memzWe || busy) sawWrite = 1;
        end
        checkOutput("idleAfterReset", 64'(sawWrite), 64'd0);
    endtask

    initial begin
        int sx, sy;
        rstn  = 1'b0;
        start = 1'b0;
        sizeX = '0;
        sizeY = '0;
        for (int k = 0; k < MAXN; k++) begin
            xMem[k] = '0;
            yMem[k] = '0;
        end
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstn = 1'b1;

        $display("[TB] directed: X=[1,2,3] Y=[1,1]");
        xMem[0] = 8'd1; xMem[1] = 8'd2; xMem[2] = 8'd3;
        yMem[0] = 8'd1; yMem[1] = 8'd1;
        applyStimulus(3, 2, 0);

        $display("[TB] directed: single sample 7*9");
        xMem[0] = 8'd7; yMem[0] = 8'd9;
        applyStimulus(1, 1, 0);

        $display("[TB] directed: zero-length X and Y");
        applyStimulus(0, 5, 0);
        applyStimulus(4, 0, 0);

        $display("[TB] directed: X=[-1,2] Y=[3]");
        xMem[0] = 8'hFF; xMem[1] = 8'd2; yMem[0] = 8'd3;
        applyStimulus(2, 1, 0);

        $display("[TB] directed: 32x32 full-scale samples");
        for (int k = 0; k < MAXN; k++) begin
            xMem[k] = 8'hFF;
            yMem[k] = 8'hFF;
        end
        applyStimulus(32, 32, 0);

        $display("[TB] directed: oversize lengths saturate");
        fillRandom();
        applyStimulus(40, 3, 0);
        applyStimulus(2, 63, 0);

        $display("[TB] start re-pulsed mid-run");
        fillRandom();
        applyStimulus(5, 4, 7);

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            fillRandom();
            sx = $urandom_range(1, 12);
            sy = $urandom_range(1, 12);
            applyStimulus(sx, sy, (r % 2 == 1) ? int'($urandom_range(2, 10)) : 0);
        end

        $display("[TB] reset mid-run");
        fillRandom();
        resetMidRun(6, 5, 15);
        fillRandom();
        applyStimulus(3, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
